// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
// pad_merge builds the padded tail of the final message block.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int BLOCK_W        = 512;
  localparam int DIGEST_W       = 256;
  localparam int BYTES_PER_BLK  = 64;
  localparam int LEN_FIELD_BYTE = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  // Bytes 0..p-1 are message data; byte p gets the 0x80 marker and the rest is
  // cleared. The length field is appended only when it still fits (p <= 55).
  function automatic logic [BLOCK_W-1:0] pad_merge(input logic [BLOCK_W-1:0] block,
                                                   input logic [6:0]         p,
                                                   input logic [63:0]        bitlen);
    logic [BLOCK_W-1:0] r;
    r = block;
    for (int i = 0; i < BYTES_PER_BLK; i++) begin
      if (i == int'(p))     r[BLOCK_W-1-8*i -: 8] = PAD_BYTE;
      else if (i > int'(p)) r[BLOCK_W-1-8*i -: 8] = 8'h00;
    end
    if (p <= 7'(LEN_FIELD_BYTE - 1)) r[63:0] = bitlen;
    return r;
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Byte-serial SHA-256 padder feeding a block-at-a-time compression core.
// Optional SHA256_PADDER_EMPTY_MSG_EN adds empty_req for zero-length messages.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic                core_start,
  output logic [BLOCK_W-1:0]  core_block,
  output logic                core_first,
  input  logic                core_ready,
  input  logic [DIGEST_W-1:0] core_digest,
  output logic [DIGEST_W-1:0] hash,
  output logic                hash_valid,
`ifdef SHA256_PADDER_EMPTY_MSG_EN
  input  logic                empty_req,
`endif
  output logic                busy
);

  localparam logic [LEN_W-1:0] LEN_MAX  = '1;
  localparam logic [LEN_W-1:0] LEN_STEP = LEN_W'(8);

  state_t             state;
  logic [BLOCK_W-1:0] blk;
  logic [6:0]         ptr;
  logic [LEN_W-1:0]   bitlen;
  logic               last_blk;
  logic               extra;
  logic               first_blk;
  logic               wait_skip;

  logic               accept;
  logic [6:0]         ptr_inc;
  logic [LEN_W-1:0]   bitlen_inc;
  logic [63:0]        len_field;
  logic [8:0]         wr_lsb;

  assign accept     = in_valid && in_ready;
  assign ptr_inc    = ptr + 7'd1;
  assign bitlen_inc = (bitlen > LEN_MAX - LEN_STEP) ? LEN_MAX : bitlen + LEN_STEP;
  assign len_field  = 64'(bitlen);
  // Byte k lives at bits 511-8k..504-8k, so its LSB index is (63-k)*8.
  assign wr_lsb     = {~ptr[5:0], 3'b000};
  assign core_block = blk;

  // NOTE: every register here is updated with <= so all branches see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      // NOTE: the block buffer is reset too, because it is visible on core_block.
      blk        <= '0;
      ptr        <= '0;
      bitlen     <= '0;
      last_blk   <= 1'b0;
      extra      <= 1'b0;
      first_blk  <= 1'b0;
      wait_skip  <= 1'b0;
      in_ready   <= 1'b0;
      core_start <= 1'b0;
      core_first <= 1'b0;
      hash       <= '0;
      hash_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      core_start <= 1'b0;
      core_first <= 1'b0;
      hash_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            blk[wr_lsb +: 8] <= in_data;
            bitlen           <= bitlen_inc;
            if (state == ST_IDLE) begin
              busy      <= 1'b1;
              first_blk <= 1'b1;
            end
            if (in_last) begin
              ptr      <= ptr_inc;
              in_ready <= 1'b0;
              state    <= ST_PAD;
            end else if (ptr_inc == 7'(BYTES_PER_BLK)) begin
              ptr      <= '0;
              last_blk <= 1'b0;
              extra    <= 1'b0;
              in_ready <= 1'b0;
              state    <= ST_ISSUE;
            end else begin
              ptr   <= ptr_inc;
              state <= ST_FILL;
            end
          end
`ifdef SHA256_PADDER_EMPTY_MSG_EN
          else if (state == ST_IDLE && empty_req) begin
            blk       <= {PAD_BYTE, {(BLOCK_W-8){1'b0}}};
            last_blk  <= 1'b1;
            extra     <= 1'b0;
            first_blk <= 1'b1;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
            state     <= ST_ISSUE;
          end
`endif
        end
        ST_PAD: begin
          blk      <= pad_merge(blk, ptr, len_field);
          last_blk <= (ptr <= 7'(LEN_FIELD_BYTE - 1));
          extra    <= (ptr >= 7'(LEN_FIELD_BYTE));
          state    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          core_start <= 1'b1;
          core_first <= first_blk;
          first_blk  <= 1'b0;
          wait_skip  <= 1'b1;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // core_ready still shows the previous block's status while start is high.
          if (wait_skip) begin
            wait_skip <= 1'b0;
          end else if (core_ready) begin
            if (last_blk) begin
              hash       <= core_digest;
              hash_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_DONE;
            end else if (extra) begin
              blk      <= {(ptr == 7'(BYTES_PER_BLK)) ? PAD_BYTE : 8'h00,
                           {(BLOCK_W-72){1'b0}}, len_field};
              last_blk <= 1'b1;
              extra    <= 1'b0;
              state    <= ST_ISSUE;
            end else begin
              in_ready <= 1'b1;
              state    <= ST_FILL;
            end
          end
        end
        ST_DONE: begin
          ptr      <= '0;
          bitlen   <= '0;
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Front-end that drives sha256_compact's start/block/ready interface. It accepts a byte-serial message and applies SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length). It issues each 512-bit block to the core and waits for completion before issuing the next. When the final block completes, it presents the digest.

Parameters:
LEN_W, 64, width of the message bit-length counter; the value is zero-extended into the 64-bit length field.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
in_valid  in  1  message byte valid
in_ready  out  1  padder can accept a byte
in_data  in  8  message byte; the first byte lands in block[511:504]
in_last  in  1  qualifies in_data as the final byte of the message
core_start  out  1  one-cycle pulse to the core's start input
core_block  out  512  block driven to the core; stable from the start pulse until ready
core_first  out  1  high with core_start on the first block of a message (the core reloads its initial H)
core_ready  in  1  core ready; low while hashing, high when core_digest is valid
core_digest  in  256  chained digest from the core
hash  out  256  final digest, held until the next hash_valid
hash_valid  out  1  one-cycle pulse when hash updates
busy  out  1  high from the first accepted byte until hash_valid

Behaviour:
- Reset values: in_ready=0 while rst_n=0 and 1 afterwards. core_start=0, core_block=0, core_first=0, hash=0, hash_valid=0, busy=0. Byte pointer=0, bit length=0, state=IDLE.
- States: IDLE, FILL, PAD, ISSUE, WAIT, DONE.
- Byte acceptance:
  - A byte is accepted on a clock edge where in_valid and in_ready are both high.
  - in_ready=1 only in IDLE and FILL.
  - A byte accepted in IDLE goes to FILL and sets busy.
  - Each accepted byte is written to byte position ptr (ptr 0 maps to bits 511:504), then ptr++ and bitlen+=8.
- FILL:
  - ptr reaching 64 without in_last: go to ISSUE with last_blk=0 and ptr=0.
  - in_last accepted: go to PAD with p = ptr after the write (1..64).
- PAD (single cycle):
  - p<=55: write 0x80 at byte p, zero bytes p+1..55, write bitlen at bytes 56..63; go to ISSUE with last_blk=1.
  - 56<=p<=63: write 0x80 at byte p and zero the rest; go to ISSUE with last_blk=0 and extra=1. The extra block is all zeros plus bitlen.
  - p==64: go to ISSUE with last_blk=0 and extra=1. The extra block is 0x80 at byte 0, zeros, then bitlen.
- ISSUE:
  - Drive core_start=1 for exactly one cycle.
  - core_first=1 only for the first block since IDLE.
  - Go to WAIT.
- WAIT:
  - Ignore core_ready in the cycle after core_start.
  - After that, stay until core_ready=1.
  - Then:
    - if last_blk, go to DONE;
    - else if extra, load the extra block, set last_blk=1, clear extra, go to ISSUE;
    - else go to FILL with in_ready=1.
- DONE:
  - Latch hash<=core_digest and pulse hash_valid for 1 cycle.
  - Clear ptr, bitlen and busy; go to IDLE.
- Latency: last byte accepted -> core_start = 2 cycles (PAD, ISSUE). Core ready -> hash_valid = 1 cycle.
- Block buffer bytes beyond ptr are don't-care during FILL and are always zeroed before issue.
- in_valid without in_ready: the byte is not consumed; the source holds it.
- Bit length saturates at 2^LEN_W-1; no error is flagged.
- Reset mid-operation: all state clears immediately; the partial message is discarded. core_start is never pulsed while rst_n=0. The core is reset by its own rst_n.

Optional Feature:
SHA256_PADDER_EMPTY_MSG_EN
- Defined: adds input empty_req (1 bit). A pulse while in IDLE with no in_valid issues a single block 0x80 followed by zeros (length 0), with core_first=1. empty_req outside IDLE is ignored; in_valid wins if both are asserted in IDLE.
- Undefined: the port is absent and zero-length messages are unsupported.

Decomposition:
- Package sha256_pkg holds:
  - the state enum;
  - BLOCK_W=512, DIGEST_W=256, BYTES_PER_BLK=64, LEN_FIELD_BYTE=56, PAD_BYTE=8'h80;
  - function pad_merge(block, p, bitlen), which returns the padded block.
- Single module; no sub-module is warranted.

Test Plan:
- "abc" (3 bytes, in_last on 0x63) -> one core_start with core_block = 61626380 00…00 00000018 and core_first=1. hash = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- 55 bytes of 0x61 -> exactly one block; byte 55 = 0x80, block[63:0] = 0x1B8.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> two blocks. The first has 0x80 at byte 56; the second is all zero except 0x1C0, with core_first=0. hash = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- 64 bytes -> two blocks. in_ready drops for the whole of both blocks. The second block = 80 00…00 00000200.
- Random in_valid gaps on "abc", plus core_ready held low for 100 cycles -> same digest; core_start pulses exactly once and never re-fires while waiting.
- Reset asserted mid-WAIT -> outputs return to reset values asynchronously. A following "abc" yields the correct digest. With the macro defined, an empty_req pulse -> hash = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
